// File: rtl/dbg_clk_sweep_pkg.sv
// dbg_clk_sweep_pkg: shared mode and state encodings for the debug clock sweeper
package dbg_clk_sweep_pkg;
  typedef enum logic [1:0] {MODE_AUTO, MODE_STEP, MODE_HOLD, MODE_RSVD} mode_e;
  typedef enum logic [1:0] {ST_RUN, ST_FREEZE, ST_LOAD} state_e;
endpackage

// File: rtl/dbg_clk_div.sv
// dbg_clk_div: half-period divider producing one registered debug clock
module dbg_clk_div #(
  parameter int CNT_WDH = 17
) (
  input  logic               i_clk,
  input  logic               reset_n,
  input  logic               i_run,
  input  logic               i_clr,
  input  logic [CNT_WDH-1:0] i_lim,
  output logic               o_clk
);
  logic [CNT_WDH-1:0] cnt, lim_m1;
  // a zero limit behaves like one so the clock still runs at i_clk/2
  assign lim_m1 = i_lim == '0 ? '0 : i_lim - 1'b1;
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      o_clk <= 1'b0;
    end else if (i_clr) begin
      cnt   <= '0;
      o_clk <= 1'b0;
    end else if (i_run) begin
      cnt   <= cnt == lim_m1 ? '0 : cnt + 1'b1;
      o_clk <= cnt == lim_m1 ? ~o_clk : o_clk;
    end
  end
endmodule

// File: rtl/dbg_clk_sweep.sv
// dbg_clk_sweep: mixed-radix sweep of divider settings across NUM_CLKS debug clocks
module dbg_clk_sweep
  import dbg_clk_sweep_pkg::*;
#(
  parameter int NUM_CLKS  = 4,
  parameter int NUM_LIMS  = 7,
  parameter int IDX_WDH   = 3,
  parameter int CNT_WDH   = 17,
  parameter logic [NUM_LIMS*CNT_WDH-1:0] LIM_TABLE =
    {17'd65536, 17'd4096, 17'd1024, 17'd64, 17'd16, 17'd4, 17'd2},
  parameter int DWELL_CKS = 250000
) (
  input  logic                        i_clk,
  input  logic                        reset_n,
  input  logic [1:0]                  i_mode,
  input  logic                        i_step,
  input  logic                        i_set,
  input  logic [NUM_CLKS*IDX_WDH-1:0] i_set_idxs,
  output logic [NUM_CLKS-1:0]         o_clk,
  output logic [NUM_CLKS*IDX_WDH-1:0] o_idxs,
  output logic                        o_busy,
  output logic                        o_wrap,
  output logic [7:0]                  o_sweep_cnt
);
  localparam int DW = $clog2(DWELL_CKS);
  localparam logic [IDX_WDH-1:0] DMAX = IDX_WDH'(NUM_LIMS - 1);
  state_e state;
  mode_e mode, mode_q;
  logic [NUM_CLKS*IDX_WDH-1:0] adv_idxs, set_clamp, set_q;
  logic [DW-1:0] dwell;
  logic carry, req_set_q, auto_exp, req;
  assign mode = mode_e'(i_mode);
  always_comb begin
    carry     = 1'b1;
    adv_idxs  = o_idxs;
    set_clamp = i_set_idxs;
    for (int k = 0; k < NUM_CLKS; k++) begin
      adv_idxs[k*IDX_WDH +: IDX_WDH] = !carry ? o_idxs[k*IDX_WDH +: IDX_WDH] :
        o_idxs[k*IDX_WDH +: IDX_WDH] == DMAX ? '0 : o_idxs[k*IDX_WDH +: IDX_WDH] + 1'b1;
      carry = carry && o_idxs[k*IDX_WDH +: IDX_WDH] == DMAX;
      set_clamp[k*IDX_WDH +: IDX_WDH] = i_set_idxs[k*IDX_WDH +: IDX_WDH] > DMAX ? DMAX :
        i_set_idxs[k*IDX_WDH +: IDX_WDH];
    end
  end
  assign auto_exp = mode == MODE_AUTO && mode_q == mode && dwell == DW'(DWELL_CKS - 1);
  assign req      = i_set || auto_exp || (mode == MODE_STEP && i_step);
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_RUN;
      mode_q      <= MODE_AUTO;
      o_idxs      <= '0;
      set_q       <= '0;
      req_set_q   <= 1'b0;
      dwell       <= '0;
      o_busy      <= 1'b0;
      o_wrap      <= 1'b0;
      o_sweep_cnt <= '0;
    end else begin
      mode_q <= mode;
      case (state)
        ST_RUN: begin
          dwell <= mode != mode_q ? '0 : mode == MODE_AUTO ? dwell + 1'b1 : dwell;
          if (req) begin
            state     <= ST_FREEZE;
            o_busy    <= 1'b1;
            req_set_q <= i_set;
            set_q     <= set_clamp;
          end
        end
        ST_FREEZE: begin
          state  <= ST_LOAD;
          // digits are stable here, so the wrap pulse can line up with LOAD
          o_wrap <= !req_set_q && carry;
        end
        ST_LOAD: begin
          state       <= ST_RUN;
          o_busy      <= 1'b0;
          o_wrap      <= 1'b0;
          o_idxs      <= req_set_q ? set_q : adv_idxs;
          dwell       <= '0;
          o_sweep_cnt <= o_wrap ? o_sweep_cnt + 1'b1 : o_sweep_cnt;
        end
        default: state <= ST_RUN;
      endcase
    end
  end
  for (genvar k = 0; k < NUM_CLKS; k++) begin : g_div
    dbg_clk_div #(.CNT_WDH(CNT_WDH)) u_div (
      .i_clk  (i_clk),
      .reset_n(reset_n),
      .i_run  (state == ST_RUN),
      .i_clr  (state == ST_LOAD),
      .i_lim  (LIM_TABLE[int'(o_idxs[k*IDX_WDH +: IDX_WDH])*CNT_WDH +: CNT_WDH]),
      .o_clk  (o_clk[k])
    );
  end
endmodule
